// File: rtl/tmr0_wdt_ctrl_pkg.sv
// Shared constants and helpers for the Timer0 / watchdog controller.
package tmr0_wdt_ctrl_pkg;

  // OPTION register field positions: {T0CS, T0SE, PSA, PS[2:0]}
  localparam int OPT_T0CS  = 5;
  localparam int OPT_T0SE  = 4;
  localparam int OPT_PSA   = 3;
  localparam int OPT_PS_HI = 2;
  localparam int OPT_PS_LO = 0;

  // OPTION comes out of reset with every bit set (external clock, WDT owns prescaler, max ratio)
  localparam logic [5:0] OPTION_RST = 6'h3F;

  // Number of instruction cycles TMR0 ignores its source after being written
  localparam logic [1:0] TMR0_INHIBIT = 2'd2;

  // Mask with the low n bits set, n in 0..8
  function automatic logic [7:0] low_mask(input logic [3:0] n);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) begin
      m[i] = (4'(i) < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/tmr0_wdt_ctrl_t0cki_sync.sv
// T0CKI pin synchroniser with selectable edge detect.
// ext_edge_o is combinational from the last two flops, so the controller acts on
// a pin transition at the third clk edge after it.
module tmr0_wdt_ctrl_t0cki_sync (
  input  logic clk,
  input  logic rst,
  input  logic t0cki_i,
  input  logic t0se_i,
  output logic ext_edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic edge_q;

  // Two-flop synchroniser for the asynchronous pin, then a history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= t0cki_i;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  // T0SE=0 selects the rising edge, T0SE=1 the falling edge
  always_comb begin
    if (t0se_i) begin
      ext_edge_o = edge_q & ~sync2_q;
    end else begin
      ext_edge_o = sync2_q & ~edge_q;
    end
  end

endmodule

// File: rtl/tmr0_wdt_ctrl.sv
// Timer0 / watchdog controller: OPTION register, shared 8-bit prescaler,
// TMR0 clock source selection, WDT base counter and sleep tracking.
module tmr0_wdt_ctrl
  import tmr0_wdt_ctrl_pkg::*;
#(
  parameter int WDT_W = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cyc_en,
  input  logic       option_wr,
  input  logic [5:0] option_in,
  input  logic       tmr0_wr,
  input  logic       clrwdt,
  input  logic       sleep,
  input  logic       wdt_en,
  input  logic       t0cki,
  output logic       tmr0_inc,
  output logic       wdtmr,
  output logic       asleep,
  output logic [5:0] option_q
);

  logic [5:0]       option_d;
  logic [7:0]       presc_q;
  logic [7:0]       presc_d;
  logic [WDT_W-1:0] wdt_q;
  logic [WDT_W-1:0] wdt_d;
  logic [1:0]       inhibit_q;
  logic [1:0]       inhibit_d;
  logic             asleep_q;
  logic             asleep_d;
  logic             tmr0_inc_q;
  logic             tmr0_inc_d;
  logic             wdtmr_q;
  logic             wdtmr_d;

  logic             ext_edge_s;
  logic             psa_s;
  logic [2:0]       ps_s;
  logic             src_tick_s;
  logic             wdt_clr_s;
  logic             wdt_base_s;
  logic [7:0]       tmr0_mask_s;
  logic [7:0]       wdt_mask_s;
  logic             presc_clr_s;
  logic             presc_inc_s;

  tmr0_wdt_ctrl_t0cki_sync u_t0cki_sync (
    .clk        (clk),
    .rst        (rst),
    .t0cki_i    (t0cki),
    .t0se_i     (option_q[OPT_T0SE]),
    .ext_edge_o (ext_edge_s)
  );

  // Tick qualification, prescaler ownership and next-state for every register
  always_comb begin
    psa_s = option_q[OPT_PSA];
    ps_s  = option_q[OPT_PS_HI:OPT_PS_LO];

    // Source tick is dropped while asleep, during the post-write inhibit and on the write itself
    src_tick_s = (option_q[OPT_T0CS] ? ext_edge_s : cyc_en)
               & ~asleep_q & (inhibit_q == 2'd0) & ~tmr0_wr;

    // CLRWDT/SLEEP swallow a coincident WDT wrap
    wdt_clr_s  = clrwdt | sleep;
    wdt_base_s = wdt_en & (wdt_q == {WDT_W{1'b1}}) & ~wdt_clr_s;

    tmr0_mask_s = low_mask({1'b0, ps_s} + 4'd1);
    wdt_mask_s  = low_mask({1'b0, ps_s});

    if (psa_s) begin
      tmr0_inc_d = src_tick_s;
      wdtmr_d    = wdt_base_s & ((presc_q & wdt_mask_s) == wdt_mask_s);
    end else begin
      tmr0_inc_d = src_tick_s & ((presc_q & tmr0_mask_s) == tmr0_mask_s);
      wdtmr_d    = wdt_base_s;
    end

    // Any clear beats an increment in the same edge
    presc_clr_s = (option_wr & (option_in[OPT_PSA] != psa_s))
                | (tmr0_wr & ~psa_s)
                | (wdt_clr_s & psa_s)
                | (wdtmr_d & psa_s);
    presc_inc_s = psa_s ? wdt_base_s : src_tick_s;

    if (presc_clr_s) begin
      presc_d = 8'd0;
    end else if (presc_inc_s) begin
      presc_d = presc_q + 8'd1;
    end else begin
      presc_d = presc_q;
    end

    // Base counter wraps naturally, which is also the post-timeout clear
    if (wdt_clr_s) begin
      wdt_d = {WDT_W{1'b0}};
    end else if (wdt_en) begin
      wdt_d = wdt_q + {{(WDT_W-1){1'b0}}, 1'b1};
    end else begin
      wdt_d = wdt_q;
    end

    if (tmr0_wr) begin
      inhibit_d = TMR0_INHIBIT;
    end else if ((inhibit_q != 2'd0) && cyc_en) begin
      inhibit_d = inhibit_q - 2'd1;
    end else begin
      inhibit_d = inhibit_q;
    end

    if (option_wr) begin
      option_d = option_in;
    end else begin
      option_d = option_q;
    end

    // A timeout pulse is the wake-up event
    if (sleep) begin
      asleep_d = 1'b1;
    end else if (wdtmr_d) begin
      asleep_d = 1'b0;
    end else begin
      asleep_d = asleep_q;
    end
  end

  // State and output registers; reset overrides every pending event
  always_ff @(posedge clk) begin
    if (rst) begin
      option_q   <= OPTION_RST;
      presc_q    <= 8'd0;
      wdt_q      <= {WDT_W{1'b0}};
      inhibit_q  <= 2'd0;
      asleep_q   <= 1'b0;
      tmr0_inc_q <= 1'b0;
      wdtmr_q    <= 1'b0;
    end else begin
      option_q   <= option_d;
      presc_q    <= presc_d;
      wdt_q      <= wdt_d;
      inhibit_q  <= inhibit_d;
      asleep_q   <= asleep_d;
      tmr0_inc_q <= tmr0_inc_d;
      wdtmr_q    <= wdtmr_d;
    end
  end

  assign tmr0_inc = tmr0_inc_q;
  assign wdtmr    = wdtmr_q;
  assign asleep   = asleep_q;

endmodule

// File: tb/tb_tmr0_wdt_ctrl.sv
// Scoreboard bench for tmr0_wdt_ctrl (WDT_W = 4).
module tb_tmr0_wdt_ctrl;

  localparam int WDT_W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cyc_en;
  logic       option_wr;
  logic [5:0] option_in;
  logic       tmr0_wr;
  logic       clrwdt;
  logic       sleep;
  logic       wdt_en;
  logic       t0cki;
  logic       tmr0_inc;
  logic       wdtmr;
  logic       asleep;
  logic [5:0] option_q;

  int n_vec  = 0;
  int n_err  = 0;
  int pulses = 0;

  typedef struct packed {
    logic inc;
    logic wdt;
    logic slp;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  tmr0_wdt_ctrl #(.WDT_W(WDT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cyc_en    (cyc_en),
    .option_wr (option_wr),
    .option_in (option_in),
    .tmr0_wr   (tmr0_wr),
    .clrwdt    (clrwdt),
    .sleep     (sleep),
    .wdt_en    (wdt_en),
    .t0cki     (t0cki),
    .tmr0_inc  (tmr0_inc),
    .wdtmr     (wdtmr),
    .asleep    (asleep),
    .option_q  (option_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Queue the expected outputs for the coming edge, clock it, then compare
  task automatic step(input logic e_inc, input logic e_wdt, input logic e_slp);
    exp_t e;
    e.inc = e_inc;
    e.wdt = e_wdt;
    e.slp = e_slp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("tmr0_inc", 32'(tmr0_inc), 32'(e.inc));
    chk("wdtmr",    32'(wdtmr),    32'(e.wdt));
    chk("asleep",   32'(asleep),   32'(e.slp));
  endtask

  task automatic clr_in();
    rst       = 1'b0;
    cyc_en    = 1'b0;
    option_wr = 1'b0;
    option_in = 6'd0;
    tmr0_wr   = 1'b0;
    clrwdt    = 1'b0;
    sleep     = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    wdt_en = 1'b0;
    t0cki  = 1'b0;
    rst    = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rst_option", 32'(option_q), 32'h3F);
    chk("rst_presc",  32'(dut.presc_q), 32'h0);
  endtask

  initial begin
    // Internal clock, PSA=0, 1:4 -> every 4th cyc_en
    do_reset();
    option_wr = 1'b1;
    option_in = 6'b000001;
    step(1'b0, 1'b0, 1'b0);
    option_wr = 1'b0;
    chk("t1_option", 32'(option_q), 32'h01);
    cyc_en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step((i % 4) == 3, 1'b0, 1'b0);
      if (tmr0_inc) pulses++;
    end
    chk("t1_pulses", 32'(pulses), 32'd10);

    // Reset OPTION: T0CKI falling edge, 1:1; cyc_en must be ignored
    do_reset();
    cyc_en = 1'b1;
    for (int j = 0; j < 10; j++) begin
      t0cki = (j < 5);
      step(j == 7, 1'b0, 1'b0);
    end

    // T0CKI rising edge, PSA=0, 1:2, pin period 10 clk
    do_reset();
    option_wr = 1'b1;
    option_in = 6'b100000;
    step(1'b0, 1'b0, 1'b0);
    option_wr = 1'b0;
    cyc_en = 1'b1;
    pulses = 0;
    for (int j = 0; j < 60; j++) begin
      t0cki = ((j % 10) < 5);
      step((j == 12) || (j == 32) || (j == 52), 1'b0, 1'b0);
      if (tmr0_inc) pulses++;
    end
    chk("t2_pulses", 32'(pulses), 32'd3);

    // TMR0 write: prescaler clears, two cyc_en dropped, then counting resumes
    do_reset();
    option_wr = 1'b1;
    option_in = 6'b000000;
    step(1'b0, 1'b0, 1'b0);
    option_wr = 1'b0;
    cyc_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step((i % 2) == 1, 1'b0, 1'b0);
    end
    chk("t3_presc_pre", 32'(dut.presc_q), 32'd5);
    tmr0_wr = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    tmr0_wr = 1'b0;
    chk("t3_presc_clr", 32'(dut.presc_q), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("t3_presc_inh", 32'(dut.presc_q), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step((k % 2) == 1, 1'b0, 1'b0);
    end

    // WDT with PSA=1, 1:4: period 64 clk, CLRWDT restarts the full period
    do_reset();
    wdt_en = 1'b1;
    option_in = 6'b001010;
    pulses = 0;
    for (int t = 0; t <= 220; t++) begin
      option_wr = (t == 0);
      clrwdt    = (t == 150);
      step(1'b0, (t == 63) || (t == 127) || (t == 214), 1'b0);
      if (wdtmr) pulses++;
    end
    chk("t4_pulses", 32'(pulses), 32'd3);

    // Sleep: ticks suppressed, WDT (PSA=0) wakes after 16 clk
    do_reset();
    option_wr = 1'b1;
    option_in = 6'b000000;
    step(1'b0, 1'b0, 1'b0);
    option_wr = 1'b0;
    wdt_en = 1'b1;
    for (int t = 0; t <= 20; t++) begin
      sleep  = (t == 0);
      cyc_en = (t != 0);
      step((t == 18) || (t == 20), t == 16, t < 16);
    end

    // PSA switch clears a nonzero prescaler; rst overrides simultaneous strobes
    do_reset();
    wdt_en = 1'b1;
    for (int t = 0; t < 34; t++) begin
      step(1'b0, 1'b0, 1'b0);
    end
    chk("t6_presc_wdt", 32'(dut.presc_q), 32'd2);
    option_wr = 1'b1;
    option_in = 6'b000000;
    step(1'b0, 1'b0, 1'b0);
    option_wr = 1'b0;
    chk("t6_presc_psa", 32'(dut.presc_q), 32'd0);
    chk("t6_option",    32'(option_q),    32'h00);
    cyc_en = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("t6_presc_run", 32'(dut.presc_q), 32'd1);
    rst       = 1'b1;
    option_wr = 1'b1;
    option_in = 6'b000101;
    sleep     = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    clr_in();
    chk("t6_rst_option", 32'(option_q),    32'h3F);
    chk("t6_rst_presc",  32'(dut.presc_q), 32'd0);
    chk("t6_rst_wdt",    32'(dut.wdt_q),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
